// File: rtl/dmem_if.sv
// Load/store request and response channels between the execute stage (master)
// and a data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one outstanding request, programmable wait
// states, byte/half/word access to a byte-lane-split internal array.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2      // legal range 1..15
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIM  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;

    logic        write_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic        rsp_error_reg;
    logic        load_ok_reg;

    logic        accept;
    logic        commit;

    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [3:0]  cur_be;
    logic [31:0] cur_wlanes;

    logic [IDX_W-1:0] mem_idx;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] rd_word;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign accept        = bus.req_valid && (state_reg == IDLE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    count_next = LAT_M1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With LATENCY==1 the commit edge is the accept edge, so the live request
    // inputs must be used instead of the (not yet loaded) latched copy.
    always_comb begin
        if (state_reg == IDLE) begin
            cur_write  = bus.req_write;
            cur_funct3 = bus.req_funct3;
            cur_addr   = bus.req_addr;
            cur_wdata  = bus.req_wdata;
        end else begin
            cur_write  = write_reg;
            cur_funct3 = funct3_reg;
            cur_addr   = addr_reg;
            cur_wdata  = wdata_reg;
        end
    end

    // ------------------------------------------------------------------
    // Legality check, lane enables and lane-replicated store data
    // ------------------------------------------------------------------
    always_comb begin
        cur_err    = 1'b0;
        cur_be     = 4'b0000;
        cur_wlanes = cur_wdata;
        if (cur_write) begin
            case (cur_funct3)
                3'd0: begin
                    cur_be     = 4'b0001 << cur_addr[1:0];
                    cur_wlanes = {4{cur_wdata[7:0]}};
                end
                3'd1: begin
                    cur_err    = cur_addr[0];
                    cur_be     = cur_addr[1] ? 4'b1100 : 4'b0011;
                    cur_wlanes = {2{cur_wdata[15:0]}};
                end
                3'd2: begin
                    cur_err    = (cur_addr[1:0] != 2'b00);
                    cur_be     = 4'b1111;
                end
                default: cur_err = 1'b1;
            endcase
        end else begin
            case (cur_funct3)
                3'd0, 3'd4: cur_err = 1'b0;
                3'd1, 3'd5: cur_err = cur_addr[0];
                3'd2:       cur_err = (cur_addr[1:0] != 2'b00);
                default:    cur_err = 1'b1;
            endcase
        end
        if (cur_addr[31:2] >= DEPTH_LIM) begin
            cur_err = 1'b1;
        end
    end

    assign mem_idx = cur_addr[IDX_W+1:2];
    assign mem_we  = commit && !rst && cur_write  && !cur_err;
    assign mem_re  = commit && !rst && !cur_write && !cur_err;

    // ------------------------------------------------------------------
    // One byte-wide array per lane so each lane has its own write enable
    // and a registered read port.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (mem_we && cur_be[gi]) begin
                    lane_mem[mem_idx] <= cur_wlanes[gi*8 +: 8];
                end
                if (mem_re) begin
                    rd_byte_reg <= lane_mem[mem_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, latched request and response flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 4'd0;
            write_reg     <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            rsp_error_reg <= 1'b0;
            load_ok_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                write_reg  <= bus.req_write;
                funct3_reg <= bus.req_funct3;
                addr_reg   <= bus.req_addr;
                wdata_reg  <= bus.req_wdata;
            end
            if (commit) begin
                rsp_error_reg <= cur_err;
                load_ok_reg   <= !cur_write && !cur_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extension from the registered read word; the latched funct3 and
    // address are stable for the whole RESP state, so the result is too.
    // ------------------------------------------------------------------
    always_comb begin
        sel_byte = rd_word[7:0];
        case (addr_reg[1:0])
            2'd0: sel_byte = rd_word[7:0];
            2'd1: sel_byte = rd_word[15:8];
            2'd2: sel_byte = rd_word[23:16];
            2'd3: sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
        sel_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_reg)
            3'd0:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    ext_data = {24'd0, sel_byte};
            3'd1:    ext_data = {{16{sel_half[15]}}, sel_half};
            3'd5:    ext_data = {16'd0, sel_half};
            3'd2:    ext_data = rd_word;
            default: ext_data = 32'd0;
        endcase
    end

    assign bus.rsp_rdata = load_ok_reg ? ext_data : 32'd0;
    assign bus.rsp_error = rsp_error_reg;

endmodule
